// File: rtl/ysyx_24080014_defs.sv
// Shared constants for the ysyx_24080014 load/store unit.
// funct3 encodings, FSM state codes and the default WAIT timeout.
package ysyx_24080014_defs;

  localparam int LSU_TIMEOUT = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_REQ  = 2'd1;
  localparam lsu_state_t S_WAIT = 2'd2;
  localparam lsu_state_t S_DONE = 2'd3;

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Combinational lane logic: byte mask, store shift, misalign, load extract.
// i_funct3/i_off select width and lane; o_* are the derived lane values.
module ysyx_24080014_lsu_align
  import ysyx_24080014_defs::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_ldata
);

  logic [4:0]  w_sh;
  logic [31:0] w_word;

  assign w_sh    = {i_off, 3'b000};
  assign o_wdata = i_sdata << w_sh;
  assign w_word  = i_rdata >> w_sh;

  // Unsupported encodings fall into default and count as misaligned.
  always_comb begin
    o_misalign = 1'b1;
    case (i_funct3)
      F3_LB, F3_LBU: o_misalign = 1'b0;
      F3_LH, F3_LHU: o_misalign = i_off[0];
      F3_LW:         o_misalign = |i_off;
      default:       o_misalign = 1'b1;
    endcase
  end

  always_comb begin
    o_wmask = 4'b1111;
    case (i_funct3)
      F3_SB:   o_wmask = 4'b0001 << i_off;
      F3_SH:   o_wmask = 4'b0011 << i_off;
      default: o_wmask = 4'b1111;
    endcase
  end

  always_comb begin
    o_ldata = '0;
    case (i_funct3)
      F3_LB:   o_ldata = {{24{w_word[7]}}, w_word[7:0]};
      F3_LBU:  o_ldata = {24'b0, w_word[7:0]};
      F3_LH:   o_ldata = {{16{w_word[15]}}, w_word[15:0]};
      F3_LHU:  o_ldata = {16'b0, w_word[15:0]};
      F3_LW:   o_ldata = w_word;
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: EXU request in, one word-aligned memory access, result to WBU.
// Ports: EXU side (in_*, is_*, funct3, addr, store_data), WBU side (out_*), mem_* bus.
module ysyx_24080014_lsu
  import ysyx_24080014_defs::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        mem_err,
  output logic        mem_valid,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_din,
  input  logic        mem_ready,
  input  logic [31:0] mem_dout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  lsu_state_t    r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_sdata;
  logic [31:0]   r_data;
  logic [2:0]    r_f3;
  logic          r_load;
  logic          r_store;
  logic          r_mis;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_idle;
  logic          w_req;
  logic          w_wait;
  logic          w_done;
  logic [2:0]    w_f3;
  logic [1:0]    w_off;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ldata;
  logic          w_mis;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = (r_state == S_REQ);
  assign w_wait = (r_state == S_WAIT);
  assign w_done = (r_state == S_DONE);

  // In IDLE the misalign decision must come from the live request;
  // afterwards everything is derived from the latched copy.
  assign w_f3  = w_idle ? funct3 : r_f3;
  assign w_off = w_idle ? addr[1:0] : r_addr[1:0];

  ysyx_24080014_lsu_align u_align (
    .i_funct3   (w_f3),
    .i_off      (w_off),
    .i_sdata    (r_sdata),
    .i_rdata    (mem_dout),
    .o_wmask    (w_mask),
    .o_wdata    (w_wdata),
    .o_misalign (w_mis),
    .o_ldata    (w_ldata)
  );

  assign in_ready  = w_idle;
  assign out_valid = w_done;
  assign load_data = r_data;
  assign misalign  = r_mis;
  assign mem_err   = r_err;
  assign mem_valid = w_req;
  assign mem_ren   = w_req & r_load;
  assign mem_wen   = w_req & r_store;
  assign mem_raddr = {r_addr[31:2], 2'b00};
  assign mem_waddr = {r_addr[31:2], 2'b00};
  assign mem_din   = mem_wen ? w_wdata : '0;
  assign mem_wmask = {4'b0000, mem_wen ? w_mask : 4'b0000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_sdata <= '0;
      r_data  <= '0;
      r_f3    <= '0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_addr  <= addr;
            r_sdata <= store_data;
            r_f3    <= funct3;
            r_load  <= is_load;
            r_store <= is_store;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            if (!(is_load | is_store)) begin
              r_mis   <= 1'b0;
              r_state <= S_DONE;
            end else if (w_mis) begin
              r_mis   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mis   <= 1'b0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!r_load) begin
            r_state <= S_DONE;
          end else if (mem_ready) begin
            r_data  <= w_ldata;
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            r_data  <= w_ldata;
            r_state <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
